bit_field_extractor: RTL and testbench

// Unpacks variable-length bit fields from a stream of fixed-width words, LSB-first.

---
 rtl/bit_field_extractor.sv | 96 +++++++++
 tb/tb_bit_field_extractor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bit_field_extractor.sv
// LSB-first bit-field unpacker: words enter a 2*DATA_WIDTH buffer, fields of 0..DATA_WIDTH bits leave from the bottom.
// Optional synchronous clear port enabled by defining BIT_FIELD_EXTRACTOR_FLUSH_EN.

module barrel_shifter_right #(
  parameter int WIDTH       = 16,
  parameter int SHIFT_WIDTH = 4
) (
  input  logic [WIDTH-1:0]       data,
  input  logic [SHIFT_WIDTH-1:0] shift,
  input  logic                   pad_value,
  output logic [WIDTH-1:0]       result
);
  logic [WIDTH-1:0] stage [SHIFT_WIDTH+1];

  assign stage[0] = data;

  // Each stage shifts by 2**i; every stage amount stays below WIDTH for the sizes used here.
  for (genvar i = 0; i < SHIFT_WIDTH; i++) begin : g_stage
    localparam int AMOUNT = 1 << i;
    assign stage[i+1] = shift[i] ? {{AMOUNT{pad_value}}, stage[i][WIDTH-1:AMOUNT]} : stage[i];
  end

  assign result = stage[SHIFT_WIDTH];
endmodule

module bit_field_extractor #(
  parameter int DATA_WIDTH   = 8,
  parameter int LENGTH_WIDTH = $clog2(DATA_WIDTH + 1),
  parameter int LEVEL_WIDTH  = $clog2(2 * DATA_WIDTH + 1)
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic                    write_valid,
  output logic                    write_ready,
  input  logic [LENGTH_WIDTH-1:0] read_length,
  output logic                    read_valid,
  input  logic                    read_ready,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic [LEVEL_WIDTH-1:0]  level
`ifdef BIT_FIELD_EXTRACTOR_FLUSH_EN
  ,
  input  logic                    flush
`endif
);
  localparam int BUFFER_WIDTH = 2 * DATA_WIDTH;

  logic [BUFFER_WIDTH-1:0] buffer;
  logic [BUFFER_WIDTH-1:0] shifted;
  logic [LENGTH_WIDTH-1:0] len;
  logic [LENGTH_WIDTH-1:0] rd_len;
  logic [LEVEL_WIDTH-1:0]  remaining;
  logic                    write_fire;
  logic                    read_fire;
  logic                    clear;

`ifdef BIT_FIELD_EXTRACTOR_FLUSH_EN
  assign clear = flush;
`else
  assign clear = 1'b0;
`endif

  assign len = (read_length > LENGTH_WIDTH'(DATA_WIDTH)) ? LENGTH_WIDTH'(DATA_WIDTH) : read_length;

  // Ready depends on level only, so there is no combinational read->write path.
  assign write_ready = !clear && (level <= LEVEL_WIDTH'(DATA_WIDTH));
  assign read_valid  = !clear && (level >= LEVEL_WIDTH'(len));
  assign read_data   = buffer[DATA_WIDTH-1:0] & ~({DATA_WIDTH{1'b1}} << len);

  assign write_fire = write_valid && write_ready;
  assign read_fire  = read_valid && read_ready;
  assign rd_len     = read_fire ? len : '0;
  assign remaining  = level - LEVEL_WIDTH'(rd_len);

  barrel_shifter_right #(
    .WIDTH       (BUFFER_WIDTH),
    .SHIFT_WIDTH (LENGTH_WIDTH)
  ) u_shifter (
    .data      (buffer),
    .shift     (rd_len),
    .pad_value (1'b0),
    .result    (shifted)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!resetn || clear) begin
      buffer <= '0;
      level  <= '0;
    end else begin
      // The new word lands directly above the bits that survive this cycle's read.
      buffer <= shifted | (write_fire ? (BUFFER_WIDTH'(write_data) << remaining) : '0);
      level  <= remaining + (write_fire ? LEVEL_WIDTH'(DATA_WIDTH) : '0);
    end
  end
endmodule

// File: tb/tb_bit_field_extractor.sv
// Randomized and directed bench for bit_field_extractor, checked against a queue-of-bits model.
module tb_bit_field_extractor;
  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] write_data = '0;
  logic       write_valid = 1'b0;
  logic       write_ready;
  logic [3:0] read_length = '0;
  logic       read_valid;
  logic       read_ready = 1'b0;
  logic [7:0] read_data;
  logic [4:0] level;
  logic       flush = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  bit model [$];

  always #5 clock = ~clock;

  bit_field_extractor #(.DATA_WIDTH(8)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .write_data  (write_data),
    .write_valid (write_valid),
    .write_ready (write_ready),
    .read_length (read_length),
    .read_valid  (read_valid),
    .read_ready  (read_ready),
    .read_data   (read_data),
    .level       (level)
`ifdef BIT_FIELD_EXTRACTOR_FLUSH_EN
    ,
    .flush       (flush)
`endif
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int eff_len(input logic [3:0] rl);
    return (rl > 8) ? 8 : int'(rl);
  endfunction

  function automatic logic [7:0] model_field(input int n);
    logic [7:0] v = '0;
    for (int i = 0; i < n && i < model.size(); i++) v[i] = model[i];
    return v;
  endfunction

  function automatic bit model_write_ready();
    return !flush && (model.size() <= 8);
  endfunction

  function automatic bit model_read_valid();
    return !flush && (model.size() >= eff_len(read_length));
  endfunction

  task automatic apply(input logic wv, input logic [7:0] wd, input logic [3:0] rl, input logic rr);
    write_valid = wv;
    write_data  = wd;
    read_length = rl;
    read_ready  = rr;
    #1;
    check("level", level, model.size());
    check("write_ready", write_ready, model_write_ready());
    check("read_valid", read_valid, model_read_valid());
    check("read_data", read_data, model_field(eff_len(rl)));
  endtask

  task automatic advance();
    bit wt = write_valid && model_write_ready();
    bit rt = read_ready && model_read_valid();
    int n = eff_len(read_length);
    logic [7:0] wd = write_data;
    @(posedge clock);
    if (!resetn || flush) begin
      model.delete();
    end else begin
      if (rt) repeat (n) void'(model.pop_front());
      if (wt) for (int i = 0; i < 8; i++) model.push_back(wd[i]);
    end
    #1;
  endtask

  task automatic step(input logic wv, input logic [7:0] wd, input logic [3:0] rl, input logic rr);
    apply(wv, wd, rl, rr);
    advance();
  endtask

  task automatic drain();
    while (model.size() > 0) step(1'b0, 8'h00, 4'((model.size() > 8) ? 8 : model.size()), 1'b1);
  endtask

  initial begin
    // Reset
    resetn = 1'b0;
    advance();
    advance();
    resetn = 1'b1;

    apply(1'b0, 8'h00, 4'd3, 1'b0);
    check("rst_level", level, 0);
    check("rst_write_ready", write_ready, 1);
    check("rst_read_valid_len3", read_valid, 0);
    apply(1'b0, 8'h00, 4'd0, 1'b0);
    check("rst_read_valid_len0", read_valid, 1);
    check("rst_read_data_len0", read_data, 0);

    // Single word split into 3 + 5
    step(1'b1, 8'hB4, 4'd0, 1'b0);
    apply(1'b0, 8'h00, 4'd3, 1'b1);
    check("b4_read3", read_data, 8'h04);
    advance();
    apply(1'b0, 8'h00, 4'd5, 1'b1);
    check("b4_read5", read_data, 8'h16);
    advance();
    apply(1'b0, 8'h00, 4'd1, 1'b0);
    check("b4_empty_level", level, 0);
    check("b4_empty_valid", read_valid, 0);

    // Full buffer stalls writes
    step(1'b1, 8'hFF, 4'd0, 1'b0);
    step(1'b1, 8'h00, 4'd0, 1'b0);
    apply(1'b1, 8'h77, 4'd4, 1'b1);
    check("full_level", level, 16);
    check("full_write_ready", write_ready, 0);
    check("full_read4", read_data, 8'h0F);
    advance();
    apply(1'b0, 8'h00, 4'd4, 1'b1);
    check("l12_level", level, 12);
    check("l12_write_ready", write_ready, 0);
    advance();
    apply(1'b0, 8'h00, 4'd0, 1'b0);
    check("l8_level", level, 8);
    check("l8_write_ready", write_ready, 1);
    drain();

    // Simultaneous read and write
    step(1'b1, 8'hA5, 4'd0, 1'b0);
    step(1'b0, 8'h00, 4'd3, 1'b1);
    apply(1'b1, 8'h3C, 4'd4, 1'b1);
    check("rw_level_before", level, 5);
    check("rw_read4", read_data, 8'h04);
    advance();
    apply(1'b0, 8'h00, 4'd5, 1'b1);
    check("rw_level_after", level, 9);
    check("rw_read5", read_data, 8'h19);
    advance();
    drain();

    // Saturated length
    step(1'b1, 8'h5A, 4'd0, 1'b0);
    step(1'b1, 8'hC3, 4'd0, 1'b0);
    apply(1'b0, 8'h00, 4'd12, 1'b1);
    check("sat_read12", read_data, 8'h5A);
    advance();
    apply(1'b0, 8'h00, 4'd0, 1'b0);
    check("sat_level", level, 8);
    drain();

    // Random mixed traffic
    for (int i = 0; i < 1000; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    drain();

    // Reset mid-stream at level 13
    step(1'b1, 8'h9E, 4'd0, 1'b0);
    step(1'b1, 8'h61, 4'd0, 1'b0);
    step(1'b0, 8'h00, 4'd3, 1'b1);
    apply(1'b1, 8'hFF, 4'd3, 1'b1);
    check("mid_level", level, 13);
    resetn = 1'b0;
    advance();
    resetn = 1'b1;
    apply(1'b0, 8'h00, 4'd8, 1'b0);
    check("mid_rst_level", level, 0);
    check("mid_rst_read_data", read_data, 0);
    check("mid_rst_write_ready", write_ready, 1);

`ifdef BIT_FIELD_EXTRACTOR_FLUSH_EN
    step(1'b1, 8'hD2, 4'd0, 1'b0);
    step(1'b1, 8'h4B, 4'd7, 1'b1);
    apply(1'b0, 8'h00, 4'd0, 1'b0);
    check("flush_pre_level", level, 9);
    flush = 1'b1;
    apply(1'b1, 8'hEE, 4'd1, 1'b1);
    check("flush_write_ready", write_ready, 0);
    check("flush_read_valid", read_valid, 0);
    advance();
    flush = 1'b0;
    apply(1'b0, 8'h00, 4'd1, 1'b0);
    check("flush_level", level, 0);
    check("flush_recover_ready", write_ready, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
